// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings, default source
// count and the one-hot to binary encoder used to form the cause index.
package irq_pkg;

    localparam int IRQ_N_DEFAULT = 32;
    // Upper bound on the source count that the encoder below can handle.
    localparam int IRQ_MAX_N     = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    function automatic int unsigned irq_onehot2bin(input logic [IRQ_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < IRQ_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_controller_pp_or.sv
// Log-depth prefix-OR network: y_o[i] = |x_i[i:0], so bit 0 dominates.
module pp_or #(
    parameter int N = 32
) (
    input  logic [N-1:0] x_i,
    output logic [N-1:0] y_o
);

    localparam int LVLS = $clog2(N);

    logic [N-1:0] lvl [0:LVLS];

    assign lvl[0] = x_i;

    // Each level folds in the partial result from 2^k positions lower.
    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        assign lvl[k+1] = lvl[k] | (lvl[k] << (1 << k));
    end

    assign y_o = lvl[LVLS];

endmodule

// File: rtl/irq_controller.sv
// Interrupt sequencer: pending/mask registers, priority select and a REQ/ack/eret
// FSM that holds the cause stable. Define IRQ_EDGE_TRIGGER_EN for edge-sensitive sources.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N  = IRQ_N_DEFAULT,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  irq_in,
    input  logic          mask_we,
    input  logic [N-1:0]  mask_wdata,
    input  logic          int_ack,
    input  logic          eret,
    output logic          int_req,
    output logic [CW-1:0] int_cause,
    output logic          in_service,
    output logic [N-1:0]  int_pending
);

    irq_state_e          state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [CW-1:0]       cause_q, cause_d;

    logic [N-1:0]         active;
    logic [N-1:0]         prefix;
    logic [N-1:0]         onehot;
    logic [IRQ_MAX_N-1:0] onehot_ext;
    logic [CW-1:0]        cause_sel;

    assign active = pending_q & mask_q;

    pp_or #(.N(N)) u_pp_or (
        .x_i (active),
        .y_o (prefix)
    );

    // Lowest-index active source survives; everything above it is cancelled.
    assign onehot = prefix & ~(prefix << 1);

    always_comb begin
        onehot_ext        = '0;
        onehot_ext[N-1:0] = onehot;
    end

    assign cause_sel = CW'(irq_onehot2bin(onehot_ext));

`ifdef IRQ_EDGE_TRIGGER_EN
    logic [N-1:0] irq_prev_q;
    logic [N-1:0] clr_vec;

    // A fresh rising edge in the acknowledge cycle re-arms the bit (set beats clear).
    always_comb begin
        clr_vec = '0;
        if (state_q == REQ && int_ack) begin
            clr_vec[cause_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | (irq_in & ~irq_prev_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_in;
        end
    end
`else
    always_comb begin
        pending_d = irq_in;
    end
`endif

    always_comb begin
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        int_req    = 1'b0;
        in_service = 1'b0;
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = REQ;
                    cause_d = cause_sel;
                end
            end
            REQ: begin
                int_req = 1'b1;
                if (int_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                in_service = 1'b1;
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cause_q   <= cause_d;
        end
    end

    assign int_cause   = cause_q;
    assign int_pending = active;

endmodule
